// File: rtl/tone_sequencer_if.sv
// Host-side bus of the tone sequencer: melody-table write port, playback
// control and the tone-generator / status outputs.
interface tone_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic        loop;
    logic [19:0] half_period;
    logic        tone_en;
    logic        busy;
    logic [3:0]  cur_idx;
    logic        done;

    // Host / testbench side
    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop,
        input  half_period, tone_en, busy, cur_idx, done
    );

    // Sequencer side
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop,
        output half_period, tone_en, busy, cur_idx, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a 16-entry melody table (note, octave shift, duration
// in ms) by driving a half-period value and enable to a square-wave tone
// generator, with an optional silent gap between notes and looping.
module tone_sequencer #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GAP_MS   = 10
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    tone_sequencer_if.slave  bus
);

    // Prescaler counts clock cycles inside one ms; ms counter counts ticks.
    // Together they cover 1023*TICK_DIV cycles (and GAP_MS*TICK_DIV) without wrap.
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_W  = (GAP_MS > 1023) ? $clog2(GAP_MS + 1) : 10;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  GAP_LAST = MS_W'((GAP_MS > 0) ? (GAP_MS - 1) : 0);

    localparam logic [3:0] NOTE_END = 4'hF;

    // Equal-tempered half period relative to A4 = 440 Hz, rounded to nearest.
    function automatic logic [19:0] calc_hp(input int n);
        real r;
        r = real'(CLK_HZ) / (880.0 * (2.0 ** ((real'(n) - 10.0) / 12.0)));
        return 20'($rtoi(r + 0.5));
    endfunction

    localparam logic [19:0] HP_01 = calc_hp(1);
    localparam logic [19:0] HP_02 = calc_hp(2);
    localparam logic [19:0] HP_03 = calc_hp(3);
    localparam logic [19:0] HP_04 = calc_hp(4);
    localparam logic [19:0] HP_05 = calc_hp(5);
    localparam logic [19:0] HP_06 = calc_hp(6);
    localparam logic [19:0] HP_07 = calc_hp(7);
    localparam logic [19:0] HP_08 = calc_hp(8);
    localparam logic [19:0] HP_09 = calc_hp(9);
    localparam logic [19:0] HP_10 = calc_hp(10);
    localparam logic [19:0] HP_11 = calc_hp(11);
    localparam logic [19:0] HP_12 = calc_hp(12);

    // Base half period for a note code; rests and END map to 0 (never loaded).
    function automatic logic [19:0] note_base(input logic [3:0] note);
        logic [19:0] hp;
        case (note)
            4'd1:    hp = HP_01;
            4'd2:    hp = HP_02;
            4'd3:    hp = HP_03;
            4'd4:    hp = HP_04;
            4'd5:    hp = HP_05;
            4'd6:    hp = HP_06;
            4'd7:    hp = HP_07;
            4'd8:    hp = HP_08;
            4'd9:    hp = HP_09;
            4'd10:   hp = HP_10;
            4'd11:   hp = HP_11;
            4'd12:   hp = HP_12;
            default: hp = 20'd0;
        endcase
        return hp;
    endfunction

    // Each octave up halves the period; truncation is intended.
    function automatic logic [19:0] octave_shift(input logic [19:0] base,
                                                 input logic [1:0]  oct);
        return base >> oct;
    endfunction

    // Notes 1..12 sound; 0, 13, 14 are rests; 15 is END.
    function automatic logic is_tone(input logic [3:0] note);
        return (note >= 4'd1) && (note <= 4'd12);
    endfunction

    // Zero-length notes still play for one tick.
    function automatic logic [9:0] dur_last(input logic [9:0] dur);
        return (dur == 10'd0) ? 10'd0 : dur - 10'd1;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [19:0]      r_half;
    logic             r_tone_en;
    logic             r_busy;
    logic             r_done;
    logic [PRE_W-1:0] r_pre;
    logic [MS_W-1:0]  r_ms;
    logic [9:0]       r_dur_last;
    logic [15:0]      r_table [0:15];

    logic [15:0]      w_entry;
    logic [3:0]       w_note;
    logic [1:0]       w_oct;
    logic [9:0]       w_dur;
    logic             w_tick;
    logic             w_seq_end;

    assign w_entry   = r_table[r_idx];
    assign w_note    = w_entry[15:12];
    assign w_oct     = w_entry[11:10];
    assign w_dur     = w_entry[9:0];
    assign w_tick    = (r_pre == PRE_LAST);
    assign w_seq_end = (r_idx == 4'd15) && !bus.loop;

    // Melody table: synchronous writes accepted in every state, reset to END.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 16; i++) begin
                r_table[i] <= {NOTE_END, 12'h000};
            end
        end else if (bus.wr_en) begin
            r_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Playback FSM with registered outputs; stop overrides everything.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_half     <= 20'd0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pre      <= '0;
            r_ms       <= '0;
            r_dur_last <= 10'd0;
        end else begin
            r_done <= 1'b0;
            if (bus.stop && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_tone_en <= 1'b0;
                r_pre     <= '0;
                r_ms      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            r_idx   <= 4'd0;
                            r_state <= S_FETCH;
                            r_busy  <= 1'b1;
                        end
                    end

                    S_FETCH: begin
                        if (w_note == NOTE_END) begin
                            // Looping restarts from entry 0, but an END at
                            // entry 0 would spin forever, so finish instead.
                            if (bus.loop && (r_idx != 4'd0)) begin
                                r_idx <= 4'd0;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_dur_last <= dur_last(w_dur);
                            r_pre      <= '0;
                            r_ms       <= '0;
                            r_state    <= S_PLAY;
                            // Rests leave the previous half period in place.
                            if (is_tone(w_note)) begin
                                r_half    <= octave_shift(note_base(w_note), w_oct);
                                r_tone_en <= 1'b1;
                            end
                        end
                    end

                    S_PLAY: begin
                        if (w_tick) begin
                            r_pre <= '0;
                            if (r_ms == MS_W'(r_dur_last)) begin
                                r_ms      <= '0;
                                r_tone_en <= 1'b0;
                                if (GAP_MS > 0) begin
                                    r_state <= S_GAP;
                                end else if (w_seq_end) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_idx   <= r_idx + 4'd1;
                                    r_state <= S_FETCH;
                                end
                            end else begin
                                r_ms <= r_ms + 1'b1;
                            end
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end

                    S_GAP: begin
                        if (w_tick) begin
                            r_pre <= '0;
                            if (r_ms == GAP_LAST) begin
                                r_ms <= '0;
                                // Index 15 wraps to 0 naturally when looping.
                                if (w_seq_end) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_idx   <= r_idx + 4'd1;
                                    r_state <= S_FETCH;
                                end
                            end else begin
                                r_ms <= r_ms + 1'b1;
                            end
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_tone_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.half_period = r_half;
    assign bus.tone_en     = r_tone_en;
    assign bus.busy        = r_busy;
    assign bus.cur_idx     = r_idx;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer: randomized melodies checked cycle by cycle
// against a segment-level playback model, plus directed control scenarios.
module tb_tone_sequencer;

    localparam int TICK = 10;
    localparam int GAP  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tone_sequencer_if bus ();

    tone_sequencer #(
        .CLK_HZ   (100000000),
        .TICK_DIV (TICK),
        .GAP_MS   (GAP)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tone;
        logic        busy;
        logic        done;
        logic [19:0] hp;
        logic [3:0]  idx;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] tbl [16];
    logic [19:0] model_hp;
    exp_t        exp_q [$];

    // Musical reference: A4 = 440 Hz, equal temperament, octave field halves.
    function automatic logic [19:0] ref_hp(input int note, input int oct);
        real r;
        int unsigned v;
        r = 100000000.0 / (880.0 * (2.0 ** (real'(note - 10) / 12.0)));
        v = $rtoi(r + 0.5);
        return 20'(v >> oct);
    endfunction

    function automatic exp_t mk(input logic tone, input logic busy, input logic done,
                                input logic [19:0] hp, input logic [3:0] idx);
        exp_t e;
        e.tone = tone; e.busy = busy; e.done = done; e.hp = hp; e.idx = idx;
        return e;
    endfunction

    // Expand the shadow table into the expected per-cycle output trace (loop low).
    task automatic build_expected();
        int idx;
        int note;
        int dur;
        logic tonal;
        logic [19:0] hp;
        exp_q.delete();
        idx = 0;
        hp  = model_hp;
        for (int step = 0; step < 16; step++) begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, hp, 4'(idx)));
            note = int'(tbl[idx][15:12]);
            if (note == 15) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b1, hp, 4'(idx)));
                break;
            end
            dur = int'(tbl[idx][9:0]);
            if (dur == 0) dur = 1;
            tonal = (note >= 1) && (note <= 12);
            if (tonal) hp = ref_hp(note, int'(tbl[idx][11:10]));
            for (int c = 0; c < dur * TICK; c++) exp_q.push_back(mk(tonal, 1'b1, 1'b0, hp, 4'(idx)));
            for (int c = 0; c < GAP * TICK; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, hp, 4'(idx)));
            if (idx == 15) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b1, hp, 4'(idx)));
                break;
            end
            idx++;
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, hp, 4'd0));
        model_hp = hp;
    endtask

    task automatic write_entry(input int addr, input logic [15:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
        tbl[addr] = data;
    endtask

    // Pulse start and compare every cycle to the model; optionally re-pulse
    // start at cycle inject_at, which must change nothing.
    task automatic play_check(input string tag, input int inject_at);
        exp_t e;
        int   nfail;
        build_expected();
        nfail = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = (k == inject_at);
            e = exp_q[k];
            checks++;
            if ({bus.tone_en, bus.busy, bus.done, bus.half_period} !== {e.tone, e.busy, e.done, e.hp}
                || (e.busy && (bus.cur_idx !== e.idx))) begin
                failures++;
                nfail++;
                if (nfail <= 5)
                    $display("FAIL %s cycle %0d: got tone=%b busy=%b done=%b hp=%0d idx=%0d want tone=%b busy=%b done=%b hp=%0d idx=%0d",
                             tag, k, bus.tone_en, bus.busy, bus.done, bus.half_period, bus.cur_idx,
                             e.tone, e.busy, e.done, e.hp, e.idx);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({bus.half_period, bus.tone_en, bus.busy, bus.done, bus.cur_idx} !== 27'd0) begin
            failures++;
            $display("FAIL %s: got hp=%0d tone=%b busy=%b done=%b idx=%0d want all zero",
                     tag, bus.half_period, bus.tone_en, bus.busy, bus.done, bus.cur_idx);
        end
    endtask

    task automatic test_reset();
        #1;
        check_outputs_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset_release");
    endtask

    task automatic test_basic();
        write_entry(0, 16'hA005);
        write_entry(1, 16'hF000);
        play_check("basic_a", -1);
        checks++;
        if (bus.half_period !== 20'd113636) begin
            failures++;
            $display("FAIL basic_hp: got %0d want 113636", bus.half_period);
        end
    endtask

    task automatic test_octave_rest();
        write_entry(0, 16'hA402);
        play_check("octave1", -1);
        checks++;
        if (bus.half_period !== 20'd56818) begin
            failures++;
            $display("FAIL octave_hp: got %0d want 56818", bus.half_period);
        end
        write_entry(0, 16'h0003);
        play_check("rest", -1);
    endtask

    task automatic test_start_during_play();
        write_entry(0, 16'hA005);
        play_check("start_in_play", 25);
    endtask

    task automatic test_start_stop_same();
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0) begin
                failures++;
                $display("FAIL start_stop_same cycle %0d: got busy=%b tone=%b want 0 0", k, bus.busy, bus.tone_en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(4, 0);
            for (int a = 0; a < n; a++)
                write_entry(a, {4'($urandom_range(14, 0)), 2'($urandom_range(3, 0)), 10'($urandom_range(3, 0))});
            write_entry(n, {4'hF, 12'($urandom)});
            play_check($sformatf("random%0d", it), -1);
        end
    endtask

    task automatic test_full_table();
        for (int a = 0; a < 16; a++)
            write_entry(a, {4'($urandom_range(14, 0)), 2'($urandom_range(3, 0)), 10'($urandom_range(1, 0))});
        play_check("full_table", -1);
    endtask

    task automatic test_loop_stop();
        logic [3:0] prev;
        int seen_wrap;
        int done_cnt;
        for (int a = 0; a < 16; a++) write_entry(a, 16'h1001);
        bus.loop = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        prev = bus.cur_idx;
        seen_wrap = 0;
        done_cnt = 0;
        for (int k = 0; k < 600 && seen_wrap < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            if (seen_wrap > 0) seen_wrap++;
            if (prev == 4'd15 && bus.cur_idx == 4'd0) seen_wrap = 1;
            prev = bus.cur_idx;
        end
        checks++;
        if (seen_wrap == 0) begin
            failures++;
            $display("FAIL loop_wrap: got no 15->0 wrap within 600 cycles want wrap");
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL loop_no_done: got %0d done pulses want 0", done_cnt);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        checks++;
        if (bus.tone_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL stop_abort: got tone=%b busy=%b done=%b want 0 0 0", bus.tone_en, bus.busy, bus.done);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL stop_quiet: got done=%b busy=%b want 0 0", bus.done, bus.busy);
            end
        end
        model_hp = ref_hp(1, 0);
    endtask

    task automatic test_overwrite();
        int n;
        int t;
        logic hp_bad;
        write_entry(0, 16'hA005);
        write_entry(1, 16'hF000);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (bus.tone_en !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        hp_bad = 1'b0;
        while (bus.tone_en === 1'b1 && n < 200) begin
            if (bus.half_period !== 20'd113636) hp_bad = 1'b1;
            n++;
            @(negedge clk);
            bus.wr_en   = (n == 20);
            bus.wr_addr = 4'd0;
            bus.wr_data = 16'h5005;
        end
        bus.wr_en = 1'b0;
        tbl[0] = 16'h5005;
        checks++;
        if (hp_bad || n != 50) begin
            failures++;
            $display("FAIL overwrite_current: got high=%0d hp_changed=%b want high=50 hp_changed=0", n, hp_bad);
        end
        t = 0;
        while (bus.tone_en !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.tone_en !== 1'b1 || bus.half_period !== ref_hp(5, 0) || bus.cur_idx !== 4'd0) begin
            failures++;
            $display("FAIL overwrite_next: got tone=%b hp=%0d idx=%0d want tone=1 hp=%0d idx=0",
                     bus.tone_en, bus.half_period, bus.cur_idx, ref_hp(5, 0));
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        model_hp = ref_hp(5, 0);
    endtask

    task automatic test_async_reset();
        bus.loop = 1'b0;
        write_entry(0, 16'hA005);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (bus.tone_en !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: got tone=%b want 1", bus.tone_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) tbl[a] = 16'hF000;
        model_hp = 20'd0;
    endtask

    task automatic test_all_end_loop();
        int done_cnt;
        int busy_seen;
        bus.loop = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt = 0;
        busy_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy === 1'b1) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 1 || busy_seen != 2) begin
            failures++;
            $display("FAIL all_end_loop: got done=%0d busy_cycles=%0d want done=1 busy_cycles=2", done_cnt, busy_seen);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0) begin
            failures++;
            $display("FAIL all_end_idle: got busy=%b tone=%b want 0 0", bus.busy, bus.tone_en);
        end
        bus.loop = 1'b0;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 16'd0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        for (int a = 0; a < 16; a++) tbl[a] = 16'hF000;
        model_hp = 20'd0;

        test_reset();
        test_basic();
        test_octave_rest();
        test_start_during_play();
        test_start_stop_same();
        test_random();
        test_full_table();
        test_loop_stop();
        test_overwrite();
        test_async_reset();
        test_all_end_loop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
